// File: rtl/cmd_pkg.sv
// cmd_pkg: opcodes, ACK default and FSM state encoding shared by the command responder
// Ports: none (package only)
package cmd_pkg;
    localparam logic [7:0] CMD_SET_HASH_OP   = 8'h01;
    localparam logic [7:0] CMD_SEND_TEXT_OP  = 8'h02;
    localparam logic [7:0] CMD_READ_MATCH_OP = 8'h03;
    localparam logic [7:0] CMD_TEST_OP       = 8'h04;
    localparam logic [7:0] ACK_DEFAULT       = 8'h01;
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HASH = 3'd1,
        ST_LEN  = 3'd2,
        ST_TEXT = 3'd3,
        ST_RESP = 3'd4
    } cmd_state_t;
endpackage

// File: rtl/resp_serializer.sv
// resp_serializer: sends up to 5 queued bytes over the tx_start/tx_busy handshake
// Ports: clk, reset; load/load_data/load_len queue a response (first byte in [39:32]);
//        tx_busy/tx_start/tx_data talk to the transmitter; done pulses after the last byte
module resp_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [39:0] load_data,
    input  logic [2:0]  load_len,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        done
);
    typedef enum logic [1:0] {P_IDLE, P_ISSUE, P_WAIT_HI, P_WAIT_LO} phase_t;
    phase_t      phase;
    logic [39:0] shreg;
    logic [2:0]  left;
    // each byte waits for busy to rise and then fall before the next is issued
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            phase    <= P_IDLE;
            shreg    <= '0;
            left     <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            done     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            if (load) begin
                shreg <= load_data;
                left  <= load_len;
                phase <= P_ISSUE;
            end else
                case (phase)
                    P_ISSUE:
                        if (!tx_busy && !tx_start) begin
                            tx_start <= 1'b1;
                            tx_data  <= shreg[39:32];
                            shreg    <= {shreg[31:0], 8'h00};
                            left     <= left - 1'b1;
                            phase    <= P_WAIT_HI;
                        end
                    P_WAIT_HI: if (tx_busy) phase <= P_WAIT_LO;
                    P_WAIT_LO:
                        if (!tx_busy) begin
                            done  <= (left == 3'd0);
                            phase <= (left == 3'd0) ? P_IDLE : P_ISSUE;
                        end
                    default: ;
                endcase
        end
endmodule

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: decodes host opcodes from the UART, loads the target hash, streams text, queues replies
// Ports: clk, reset (async, active-high); rx_data/rx_valid from the receiver;
//        tx_busy/tx_start/tx_data to the transmitter; match_found/match_pos from the matcher;
//        target_hash/hash_load, text_data/text_valid/text_last to the datapath; cmd_state to the LEDs
module uart_cmd_responder
    import cmd_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0] ACK_BYTE       = ACK_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    input  logic         tx_busy,
    output logic         tx_start,
    output logic [7:0]   tx_data,
    input  logic         match_found,
    input  logic [31:0]  match_pos,
    output logic [127:0] target_hash,
    output logic         hash_load,
    output logic [7:0]   text_data,
    output logic         text_valid,
    output logic         text_last,
    output logic [2:0]   cmd_state
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    cmd_state_t     state;
    logic [127:0]   hash_sh;
    logic [3:0]     cnt;
    logic [7:0]     len_hi;
    logic [15:0]    text_cnt;
    logic [TW-1:0]  gap;
    logic           ser_load;
    logic [39:0]    ser_data;
    logic [2:0]     ser_len;
    logic           ser_done;
    assign cmd_state = state;
    resp_serializer u_ser (
        .clk(clk), .reset(reset), .load(ser_load), .load_data(ser_data), .load_len(ser_len),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .done(ser_done)
    );
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state       <= ST_IDLE;
            hash_sh     <= '0;
            cnt         <= '0;
            len_hi      <= '0;
            text_cnt    <= '0;
            gap         <= '0;
            ser_load    <= 1'b0;
            ser_data    <= '0;
            ser_len     <= '0;
            target_hash <= '0;
            hash_load   <= 1'b0;
            text_data   <= '0;
            text_valid  <= 1'b0;
            text_last   <= 1'b0;
        end else begin
            hash_load  <= 1'b0;
            text_valid <= 1'b0;
            text_last  <= 1'b0;
            ser_load   <= 1'b0;
            case (state)
                ST_IDLE:
                    if (rx_valid) begin
                        gap <= '0;
                        cnt <= '0;
                        if (rx_data == CMD_SET_HASH_OP) state <= ST_HASH;
                        else if (rx_data == CMD_SEND_TEXT_OP) state <= ST_LEN;
                        else if (rx_data == CMD_READ_MATCH_OP) begin
                            ser_load <= 1'b1;
                            ser_data <= {7'd0, match_found, match_pos};
                            ser_len  <= 3'd5;
                            state    <= ST_RESP;
                        end else if (rx_data == CMD_TEST_OP) begin
                            ser_load <= 1'b1;
                            ser_data <= {32'h04030201, 8'h00};
                            ser_len  <= 3'd4;
                            state    <= ST_RESP;
                        end
                    end
                ST_HASH, ST_LEN, ST_TEXT:
                    // a byte arriving in the expiry cycle wins over the timeout
                    if (!rx_valid) begin
                        gap <= (gap == TW'(TIMEOUT_CYCLES - 1)) ? '0 : gap + 1'b1;
                        if (gap == TW'(TIMEOUT_CYCLES - 1)) state <= ST_IDLE;
                    end else begin
                        gap <= '0;
                        cnt <= cnt + 1'b1;
                        if (state == ST_HASH) begin
                            hash_sh <= {hash_sh[119:0], rx_data};
                            if (cnt == 4'd15) begin
                                target_hash <= {hash_sh[119:0], rx_data};
                                hash_load   <= 1'b1;
                                ser_load    <= 1'b1;
                                ser_data    <= {ACK_BYTE, 32'h0};
                                ser_len     <= 3'd1;
                                state       <= ST_RESP;
                            end
                        end else if (state == ST_LEN) begin
                            len_hi   <= rx_data;
                            text_cnt <= {len_hi, rx_data};
                            if (cnt[0] && {len_hi, rx_data} == 16'd0) begin
                                ser_load <= 1'b1;
                                ser_data <= {ACK_BYTE, 32'h0};
                                ser_len  <= 3'd1;
                                state    <= ST_RESP;
                            end else if (cnt[0]) state <= ST_TEXT;
                        end else begin
                            text_data  <= rx_data;
                            text_valid <= 1'b1;
                            text_cnt   <= text_cnt - 1'b1;
                            if (text_cnt == 16'd1) begin
                                text_last <= 1'b1;
                                ser_load  <= 1'b1;
                                ser_data  <= {ACK_BYTE, 32'h0};
                                ser_len   <= 3'd1;
                                state     <= ST_RESP;
                            end
                        end
                    end
                ST_RESP: if (ser_done) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb_uart_cmd_responder: directed self-checking bench for the UART command responder
module tb_uart_cmd_responder;
    localparam int T = 40;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   rx_data = '0;
    logic         rx_valid = 1'b0;
    logic         tx_busy = 1'b0;
    logic         tx_start;
    logic [7:0]   tx_data;
    logic         match_found = 1'b0;
    logic [31:0]  match_pos = '0;
    logic [127:0] target_hash;
    logic         hash_load;
    logic [7:0]   text_data;
    logic         text_valid;
    logic         text_last;
    logic [2:0]   cmd_state;
    int checks = 0;
    int errors = 0;
    logic [7:0] txq[$];
    logic [7:0] txtq[$];
    logic       lastq[$];
    int starts = 0;
    int viol = 0;
    int loads = 0;
    int bc = 0;
    logic prev_start = 1'b0;
    localparam logic [127:0] HASH = 128'ha2004f37730b9445670a738fa0fc9ee5;
    uart_cmd_responder #(.TIMEOUT_CYCLES(T), .ACK_BYTE(8'h01)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
        .tx_start(tx_start), .tx_data(tx_data), .match_found(match_found), .match_pos(match_pos),
        .target_hash(target_hash), .hash_load(hash_load), .text_data(text_data),
        .text_valid(text_valid), .text_last(text_last), .cmd_state(cmd_state)
    );
    always #5 clk = ~clk;
    // transmitter and datapath observer: busy rises after each tx_start and stays up for 4 cycles
    always @(negedge clk) begin
        if (tx_start) begin
            if (prev_start || tx_busy) viol++;
            txq.push_back(tx_data);
            starts++;
        end
        if (text_valid) begin
            txtq.push_back(text_data);
            lastq.push_back(text_last);
        end
        if (hash_load) loads++;
        prev_start = tx_start;
        if (tx_start) begin
            tx_busy = 1'b1;
            bc = 4;
        end else if (bc > 0) begin
            bc--;
            tx_busy = (bc > 0);
        end
    end
    function automatic logic [63:0] pack(input logic [7:0] q[$]);
        logic [63:0] r = '0;
        foreach (q[i]) r = {r[55:0], q[i]};
        return r;
    endfunction
    task automatic clr();
        txq.delete();
        txtq.delete();
        lastq.delete();
        starts = 0;
        viol = 0;
        loads = 0;
    endtask
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask
    task automatic idle_wait(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cmd_state == 3'd0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", cmd_state); end
        checks++;
        if (target_hash !== 128'h0) begin errors++; $display("FAIL reset_hash got %h want 0", target_hash); end
        checks++;
        if ({tx_start, tx_data, hash_load, text_valid, text_last, text_data} !== 19'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {tx_start, tx_data, hash_load, text_valid, text_last, text_data});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask
    task automatic test_hash();
        bit ok;
        logic [127:0] h = HASH;
        clr();
        send(8'h01);
        for (int i = 15; i >= 0; i--) send(h[i*8 +: 8]);
        checks++;
        if (target_hash !== HASH || hash_load !== 1'b1 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL hash_update got %h load %b start %b want %h load 1 start 0", target_hash, hash_load, tx_start, HASH);
        end
        idle_wait(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL hash_timeout got state %0d want 0", cmd_state); end
        checks++;
        if (loads != 1) begin errors++; $display("FAIL hash_load_count got %0d want 1", loads); end
        checks++;
        if (txq.size() != 1 || pack(txq) !== 64'h01 || starts != 1) begin
            errors++;
            $display("FAIL hash_ack got %h (%0d starts) want 01 (1 start)", pack(txq), starts);
        end
    endtask
    task automatic test_text();
        bit ok;
        clr();
        send(8'h02); send(8'h00); send(8'h03);
        send(8'h41); send(8'h42); send(8'h43);
        idle_wait(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL text_timeout got state %0d want 0", cmd_state); end
        checks++;
        if (txtq.size() != 3 || pack(txtq) !== 64'h414243) begin
            errors++;
            $display("FAIL text_bytes got %h (%0d) want 414243 (3)", pack(txtq), txtq.size());
        end
        checks++;
        if (lastq.size() != 3 || lastq[0] !== 1'b0 || lastq[1] !== 1'b0 || lastq[2] !== 1'b1) begin
            errors++;
            $display("FAIL text_last got size %0d want last only on third byte", lastq.size());
        end
        checks++;
        if (txq.size() != 1 || pack(txq) !== 64'h01) begin errors++; $display("FAIL text_ack got %h want 01", pack(txq)); end
    endtask
    task automatic test_test_op();
        bit ok;
        clr();
        send(8'h04);
        idle_wait(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL test_op_timeout got state %0d want 0", cmd_state); end
        checks++;
        if (txq.size() != 4 || pack(txq) !== 64'h04030201 || starts != 4 || viol != 0) begin
            errors++;
            $display("FAIL test_op got %h starts %0d viol %0d want 04030201 starts 4 viol 0", pack(txq), starts, viol);
        end
    endtask
    task automatic test_read_match();
        bit ok;
        clr();
        match_found = 1'b1;
        match_pos = 32'h00012345;
        send(8'h03);
        match_found = 1'b0;
        match_pos = 32'h0;
        idle_wait(ok);
        checks++;
        if (!ok || txq.size() != 5 || pack(txq) !== 64'h0100012345) begin
            errors++;
            $display("FAIL read_match_found got %h (%0d) want 0100012345 (5)", pack(txq), txq.size());
        end
        clr();
        match_pos = 32'hdeadbeef;
        send(8'h03);
        idle_wait(ok);
        checks++;
        if (!ok || txq.size() != 5 || pack(txq) !== 64'h00deadbeef) begin
            errors++;
            $display("FAIL read_match_none got %h (%0d) want 00deadbeef (5)", pack(txq), txq.size());
        end
    endtask
    task automatic test_invalid_op();
        clr();
        send(8'h55);
        repeat (10) @(negedge clk);
        checks++;
        if (cmd_state !== 3'd0 || txq.size() != 0) begin
            errors++;
            $display("FAIL invalid_op got state %0d tx %0d want state 0 tx 0", cmd_state, txq.size());
        end
    endtask
    task automatic test_timeout();
        bit ok;
        clr();
        send(8'h01);
        for (int i = 0; i < 5; i++) send(8'h11);
        repeat (T - 10) @(negedge clk);
        checks++;
        if (cmd_state !== 3'd1) begin errors++; $display("FAIL timeout_early got state %0d want 1", cmd_state); end
        repeat (20) @(negedge clk);
        checks++;
        if (cmd_state !== 3'd0) begin errors++; $display("FAIL timeout_expire got state %0d want 0", cmd_state); end
        checks++;
        if (txq.size() != 0 || loads != 0 || target_hash !== HASH) begin
            errors++;
            $display("FAIL timeout_side_effects got tx %0d loads %0d hash %h want 0 0 %h", txq.size(), loads, target_hash, HASH);
        end
        send(8'h04);
        idle_wait(ok);
        checks++;
        if (!ok || pack(txq) !== 64'h04030201) begin
            errors++;
            $display("FAIL timeout_recover got %h want 04030201", pack(txq));
        end
    endtask
    task automatic test_resp_drop();
        bit ok;
        clr();
        send(8'h04);
        send(8'h01);
        idle_wait(ok);
        repeat (5) @(negedge clk);
        checks++;
        if (!ok || cmd_state !== 3'd0 || pack(txq) !== 64'h04030201 || starts != 4) begin
            errors++;
            $display("FAIL resp_drop got state %0d tx %h starts %0d want 0 04030201 4", cmd_state, pack(txq), starts);
        end
    endtask
    task automatic test_reset_mid_text();
        bit ok;
        clr();
        send(8'h02); send(8'h00); send(8'h0a);
        send(8'h61); send(8'h62);
        checks++;
        if (cmd_state !== 3'd3 || text_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_text got state %0d valid %b want 3 1", cmd_state, text_valid);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (cmd_state !== 3'd0 || target_hash !== 128'h0 || text_valid !== 1'b0 || text_data !== 8'h0 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got state %0d hash %h valid %b data %h want all 0", cmd_state, target_hash, text_valid, text_data);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        clr();
        send(8'h02); send(8'h00); send(8'h00);
        idle_wait(ok);
        checks++;
        if (!ok || txq.size() != 1 || pack(txq) !== 64'h01 || txtq.size() != 0) begin
            errors++;
            $display("FAIL len_zero_ack got %h (%0d) text %0d want 01 (1) text 0", pack(txq), txq.size(), txtq.size());
        end
    endtask
    initial begin
        test_reset();
        test_hash();
        test_text();
        test_test_op();
        test_read_match();
        test_invalid_op();
        test_timeout();
        test_resp_drop();
        test_reset_mid_text();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_cmd_responder.md
# uart_cmd_responder

Device-side command responder for the MD5 search engine's host link. It consumes bytes from the UART receiver and decodes the host opcodes SET_HASH, SEND_TEXT, READ_MATCH and TEST. It loads the target hash, streams text bytes to the match pipeline, and returns ACK/response bytes through the UART transmitter handshake. It sits between async_receiver/async_transmitter and the hash/match datapath inside top_md5.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1_000_000: maximum idle gap between bytes inside a command before it is aborted.
- ACK_BYTE, 8'h01: value returned on command completion.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- rx_data  in  8  received byte; valid only while rx_valid=1.
- rx_valid  in  1  one-cycle strobe, one per received byte.
- tx_busy  in  1  transmitter busy.
- tx_start  out  1  one-cycle strobe requesting transmission of tx_data.
- tx_data  out  8  byte to transmit; held stable from tx_start until tx_busy falls.
- match_found  in  1  level; search result flag.
- match_pos  in  32  byte offset of the match.
- target_hash  out  128  loaded hash; MSB is the first byte received.
- hash_load  out  1  one-cycle strobe when target_hash updates.
- text_data  out  8  text byte to the match pipeline.
- text_valid  out  1  one-cycle strobe per text byte; no backpressure.
- text_last  out  1  asserted with the final text byte of a SEND_TEXT.
- cmd_state  out  3  current state encoding, driven to the LEDs.

## Operation
- States: IDLE, HASH, LEN, TEXT, RESP.
- IDLE: any rx_valid is an opcode.
  - 0x01 goes to HASH.
  - 0x02 goes to LEN.
  - 0x03 loads the response {0x00|0x01 flag, match_pos[31:24], [23:16], [15:8], [7:0]} (5 bytes) and goes to RESP.
  - 0x04 loads {0x04,0x03,0x02,0x01} and goes to RESP.
  - Any other opcode is ignored; the state stays IDLE.
- HASH: receive 16 bytes, MSB first, into a shift register. On the 16th byte, target_hash is updated and hash_load pulses. The response is then {ACK_BYTE} and the state goes to RESP.
- LEN: receive 2 bytes, N = {b0,b1}, MSB first.
  - N=0 sends the ACK immediately.
  - Otherwise go to TEXT.
- TEXT: each rx byte drives text_data/text_valid and decrements the counter. On the Nth byte text_last=1, then the ACK is sent.
- RESP: the serializer sends the queued bytes in order, then returns to IDLE.
- Any rx_valid during RESP is dropped.
- Timeout: in HASH/LEN/TEXT, the gap counter resets on every rx_valid. When it reaches TIMEOUT_CYCLES, the state returns to IDLE with no ACK and no hash_load. A partial hash is discarded and target_hash keeps its old value.
- match_found/match_pos are sampled in the cycle the 0x03 opcode is accepted.

## Timing
- Reset: every output is 0, target_hash=0, state=IDLE, counters 0. Reset takes effect asynchronously mid-command or mid-response. Nothing resumes after reset.
- Final hash byte strobe at cycle t gives target_hash/hash_load at t+1 and tx_start no earlier than t+2.
- rx byte at t drives text_valid at t+1 (registered).
- Transmit rule:
  - tx_start is asserted only when tx_busy=0 and tx_start was 0 in the previous cycle.
  - After tx_start, the serializer waits for tx_busy to rise, then fall, before issuing the next byte.
  - tx_data is held throughout.
- rx_valid in the same cycle as a timeout expiry: the byte wins, and the counter resets.
- The text counter is 16-bit. N=65535 is legal; there is no wrap.
- cmd_state encoding: IDLE=0, HASH=1, LEN=2, TEXT=3, RESP=4.

## Structure
- Shared package cmd_pkg holds:
  - opcode constants CMD_SET_HASH_OP=8'h01, CMD_SEND_TEXT_OP=8'h02, CMD_READ_MATCH_OP=8'h03, CMD_TEST_OP=8'h04;
  - ACK default;
  - state encoding.
- One sub-module, resp_serializer: a 5-byte load buffer plus a length field, owning the tx_start/tx_busy handshake, with a done strobe back to the main FSM.

## Test plan
- 0x01 followed by hash bytes a2,00,4f,...,e5 -> target_hash=128'ha2004f37730b9445670a738fa0fc9ee5, one hash_load, one ACK 0x01 received.
- 0x02, 0x00, 0x03, 'A','B','C' -> three text_valid strobes (41,42,43), text_last on 43, then ACK 0x01.
- 0x04 -> host receives 04,03,02,01 in order, with exactly one tx_start per byte.
- match_found=1, match_pos=32'h00012345, then 0x03 -> bytes 01,00,01,23,45.
- 0x01 then 5 bytes, then silence for TIMEOUT_CYCLES -> state IDLE, no ACK, target_hash unchanged. A following 0x04 is answered normally.
- Assert reset mid-TEXT (after 2 of 10 bytes) -> all outputs 0 at once. A subsequent 0x02/len 0 returns an ACK.
